// File: rtl/multiplier_blockbuf.sv
// ---------------------------------------------------------------------------
// multiplier_blockbuf: pipelined signed/unsigned multiplier that buffers
// products in an external 2-port memory and streams them back in order.
// Optional: MULT_BLOCKBUF_ACC_EN adds the mult_acc accumulate port.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multiplier_blockbuf #(
  parameter int IN_WIDTH    = 16,
  parameter int ADDR_WIDTH  = 6,
  parameter int PIPE_STAGES = 2,
  parameter int MEM_RD_LAT  = 1
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic                    EN_mult,
  input  logic [IN_WIDTH-1:0]     mult_input0,
  input  logic [IN_WIDTH-1:0]     mult_input1,
  input  logic                    mult_signed,
`ifdef MULT_BLOCKBUF_ACC_EN
  input  logic                    mult_acc,
`endif
  input  logic                    EN_blockRead,
  input  logic [2*IN_WIDTH-1:0]   readMem_val,
  output logic                    RDY_mult,
  output logic                    EN_writeMem,
  output logic [ADDR_WIDTH-1:0]   writeMem_addr,
  output logic [2*IN_WIDTH-1:0]   writeMem_val,
  output logic                    EN_readMem,
  output logic [ADDR_WIDTH-1:0]   readMem_addr,
  output logic                    VALID_memVal,
  output logic [2*IN_WIDTH-1:0]   memVal_data,
  output logic [ADDR_WIDTH:0]     fill_count
);

  localparam int PW   = 2 * IN_WIDTH;
  localparam int CW   = ADDR_WIDTH + 1;
  localparam int LAST = PIPE_STAGES - 1;
  localparam logic [CW-1:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_DRAIN = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    rdy_q, rdy_d;
  logic [CW-1:0]           fill_count_q, fill_count_d;
  logic [CW-1:0]           rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]           beat_cnt_q, beat_cnt_d;
  logic [PIPE_STAGES-1:0]  pv_q, pv_d;
  logic [PIPE_STAGES-1:0]  pacc_q, pacc_d;
  logic [PW-1:0]           pp_q [PIPE_STAGES];
  logic [PW-1:0]           pp_d [PIPE_STAGES];
  logic [ADDR_WIDTH-1:0]   pa_q [PIPE_STAGES];
  logic [ADDR_WIDTH-1:0]   pa_d [PIPE_STAGES];
  logic [MEM_RD_LAT-1:0]   rv_q, rv_d;
  logic [PW-1:0]           mem_data_q, mem_data_d;
  logic                    mem_valid_q, mem_valid_d;
  logic [PW-1:0]           last_q, last_d;

  logic                    accept;
  logic                    acc_in;
  logic                    rd_issue;
  logic [CW-1:0]           fill_inc;
  logic [PW-1:0]           a_ext, b_ext, prod;
  logic [PW-1:0]           wr_val;

`ifdef MULT_BLOCKBUF_ACC_EN
  assign acc_in = mult_acc;
`else
  assign acc_in = 1'b0;
`endif

  assign accept   = EN_mult && rdy_q;
  assign fill_inc = fill_count_q + {{ADDR_WIDTH{1'b0}}, accept};
  assign rd_issue = (state_q == S_READ) && (rd_cnt_q < fill_count_q);

  // Extending to PW bits first makes the low PW bits of the product exact in both modes.
  always_comb begin
    a_ext = mult_signed ? {{IN_WIDTH{mult_input0[IN_WIDTH-1]}}, mult_input0}
                        : {{IN_WIDTH{1'b0}}, mult_input0};
    b_ext = mult_signed ? {{IN_WIDTH{mult_input1[IN_WIDTH-1]}}, mult_input1}
                        : {{IN_WIDTH{1'b0}}, mult_input1};
    prod  = a_ext * b_ext;
  end

  // Entry 0 of a block never accumulates, so a stale running value cannot leak in.
  always_comb begin
    wr_val = pp_q[LAST];
    if (pacc_q[LAST] && (pa_q[LAST] != '0)) begin
      wr_val = pp_q[LAST] + last_q;
    end
    last_d = pv_q[LAST] ? wr_val : last_q;
  end

  always_comb begin
    pv_d[0]   = accept;
    pacc_d[0] = acc_in;
    pp_d[0]   = prod;
    pa_d[0]   = fill_count_q[ADDR_WIDTH-1:0];
    for (int s = 1; s < PIPE_STAGES; s++) begin
      pv_d[s]   = pv_q[s-1];
      pacc_d[s] = pacc_q[s-1];
      pp_d[s]   = pp_q[s-1];
      pa_d[s]   = pa_q[s-1];
    end
  end

  always_comb begin
    rv_d[0] = rd_issue;
    for (int s = 1; s < MEM_RD_LAT; s++) begin
      rv_d[s] = rv_q[s-1];
    end
    mem_valid_d = rv_q[MEM_RD_LAT-1];
    mem_data_d  = rv_q[MEM_RD_LAT-1] ? readMem_val : mem_data_q;
  end

  always_comb begin
    state_d      = state_q;
    rdy_d        = rdy_q;
    fill_count_d = fill_count_q;
    rd_cnt_d     = rd_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      S_FILL: begin
        fill_count_d = fill_inc;
        rdy_d        = 1'b1;
        rd_cnt_d     = '0;
        beat_cnt_d   = '0;
        if ((fill_inc == DEPTH_C) || (EN_blockRead && (fill_inc != '0))) begin
          state_d = S_DRAIN;
          rdy_d   = 1'b0;
        end
      end
      S_DRAIN: begin
        rdy_d = 1'b0;
        if (pv_q == '0) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        rdy_d = 1'b0;
        if (rd_issue) begin
          rd_cnt_d = rd_cnt_q + ONE_C;
        end
        if (mem_valid_q) begin
          beat_cnt_d = beat_cnt_q + ONE_C;
          if (beat_cnt_q == (fill_count_q - ONE_C)) begin
            state_d      = S_FILL;
            rdy_d        = 1'b1;
            fill_count_d = '0;
            rd_cnt_d     = '0;
            beat_cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_FILL;
        rdy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FILL;
      rdy_q        <= 1'b0;
      fill_count_q <= '0;
      rd_cnt_q     <= '0;
      beat_cnt_q   <= '0;
      pv_q         <= '0;
      pacc_q       <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        pp_q[s] <= '0;
        pa_q[s] <= '0;
      end
      rv_q         <= '0;
      mem_data_q   <= '0;
      mem_valid_q  <= 1'b0;
      last_q       <= '0;
    end else begin
      state_q      <= state_d;
      rdy_q        <= rdy_d;
      fill_count_q <= fill_count_d;
      rd_cnt_q     <= rd_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      pv_q         <= pv_d;
      pacc_q       <= pacc_d;
      pp_q         <= pp_d;
      pa_q         <= pa_d;
      rv_q         <= rv_d;
      mem_data_q   <= mem_data_d;
      mem_valid_q  <= mem_valid_d;
      last_q       <= last_d;
    end
  end

  assign RDY_mult      = rdy_q;
  assign EN_writeMem   = pv_q[LAST];
  assign writeMem_addr = pa_q[LAST];
  assign writeMem_val  = wr_val;
  assign EN_readMem    = rd_issue;
  assign readMem_addr  = rd_cnt_q[ADDR_WIDTH-1:0];
  assign VALID_memVal  = mem_valid_q;
  assign memVal_data   = mem_data_q;
  assign fill_count    = fill_count_q;

endmodule

`default_nettype wire

// File: tb/tb_multiplier_blockbuf.sv
// ---------------------------------------------------------------------------
// tb_multiplier_blockbuf: directed bench with a behavioural 2-port memory.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multiplier_blockbuf;

  localparam int IW    = 16;
  localparam int AW    = 6;
  localparam int PW    = 32;
  localparam int PS    = 2;
  localparam int DEPTH = 64;

  logic          CLK = 1'b0;
  logic          rst_n;
  logic          EN_mult;
  logic [IW-1:0] mult_input0, mult_input1;
  logic          mult_signed;
`ifdef MULT_BLOCKBUF_ACC_EN
  logic          mult_acc;
`endif
  logic          EN_blockRead;
  logic [PW-1:0] readMem_val;
  logic          RDY_mult, EN_writeMem, EN_readMem, VALID_memVal;
  logic [AW-1:0] writeMem_addr, readMem_addr;
  logic [PW-1:0] writeMem_val, memVal_data;
  logic [AW:0]   fill_count;

  always #5 CLK = ~CLK;

  multiplier_blockbuf dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .EN_mult      (EN_mult),
    .mult_input0  (mult_input0),
    .mult_input1  (mult_input1),
    .mult_signed  (mult_signed),
`ifdef MULT_BLOCKBUF_ACC_EN
    .mult_acc     (mult_acc),
`endif
    .EN_blockRead (EN_blockRead),
    .readMem_val  (readMem_val),
    .RDY_mult     (RDY_mult),
    .EN_writeMem  (EN_writeMem),
    .writeMem_addr(writeMem_addr),
    .writeMem_val (writeMem_val),
    .EN_readMem   (EN_readMem),
    .readMem_addr (readMem_addr),
    .VALID_memVal (VALID_memVal),
    .memVal_data  (memVal_data),
    .fill_count   (fill_count)
  );

  logic [PW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_data = '0;
  assign readMem_val = rd_data;

  always @(posedge CLK) begin
    if (EN_writeMem) mem[writeMem_addr] <= writeMem_val;
    if (EN_readMem)  rd_data <= mem[readMem_addr];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdc   = 0;
  int exp_fill = 0;
  logic [PW-1:0] exp_blk [DEPTH];

  typedef struct {
    logic [AW-1:0] addr;
    logic [PW-1:0] val;
    int            due;
  } wexp_t;
  wexp_t wq[$];

  typedef struct {
    logic [IW-1:0] a;
    logic [IW-1:0] b;
    logic          s;
    logic [PW-1:0] p;
  } vec_t;
  vec_t vt [8];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin : mon
    wexp_t e;
    if (EN_readMem) rdc++;
    if (EN_writeMem) begin
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected got addr=%0d val=%h want no write", writeMem_addr, writeMem_val);
      end else begin
        e = wq.pop_front();
        if (writeMem_addr !== e.addr || writeMem_val !== e.val || cyc != e.due) begin
          bad++;
          $display("FAIL wr_check got addr=%0d val=%h cyc=%0d want addr=%0d val=%h cyc=%0d",
                   writeMem_addr, writeMem_val, cyc, e.addr, e.val, e.due);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic put_pair(input logic [IW-1:0] a, input logic [IW-1:0] b,
                          input logic s, input logic [PW-1:0] p, input logic br);
    int    n;
    wexp_t e;
    n = 0;
    mult_input0 = a; mult_input1 = b; mult_signed = s;
    EN_mult = 1'b1; EN_blockRead = br;
    while (RDY_mult !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL rdy_timeout got RDY_mult=%b want 1 within 200 cycles", RDY_mult);
    end else begin
      e.addr = AW'(exp_fill);
      e.val  = p;
      e.due  = cyc + PS;
      wq.push_back(e);
      exp_blk[exp_fill] = p;
      exp_fill++;
      step();
    end
    EN_blockRead = 1'b0;
  endtask

  task automatic idle();
    EN_mult = 1'b0;
    EN_blockRead = 1'b0;
  endtask

  task automatic pulse_br();
    EN_blockRead = 1'b1;
    step();
    EN_blockRead = 1'b0;
  endtask

  task automatic read_block(input int n);
    int w;
    w = 0;
    while (VALID_memVal !== 1'b1 && w < 300) begin
      step();
      w++;
    end
    if (w >= 300) begin
      total++; bad++;
      $display("FAIL valid_timeout got VALID_memVal=%b want 1 within 300 cycles", VALID_memVal);
    end
    EN_mult = 1'b0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("beat%0d_valid", i), 64'(VALID_memVal), 64'd1);
      check($sformatf("beat%0d_data", i), 64'(memVal_data), 64'(exp_blk[i]));
      step();
    end
    check("valid_after", 64'(VALID_memVal), 64'd0);
    check("rdy_after", 64'(RDY_mult), 64'd1);
    check("fill_after", 64'(fill_count), 64'd0);
    check("read_count", 64'(rdc), 64'(n));
    check("writes_drained", 64'(wq.size()), 64'd0);
    exp_fill = 0;
  endtask

  initial begin
    int w;
    vt[0] = '{16'd6,    16'd4,    1'b0, 32'h0000_0018};
    vt[1] = '{16'hFFFD, 16'd5,    1'b1, 32'hFFFF_FFF1};
    vt[2] = '{16'hFFFD, 16'd5,    1'b0, 32'h0004_FFF1};
    vt[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
    vt[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001};
    vt[5] = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
    vt[6] = '{16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000};
    vt[7] = '{16'h1234, 16'h0010, 1'b0, 32'h0001_2340};

    rst_n = 1'b0; EN_mult = 1'b0; EN_blockRead = 1'b0;
    mult_input0 = '0; mult_input1 = '0; mult_signed = 1'b0;
`ifdef MULT_BLOCKBUF_ACC_EN
    mult_acc = 1'b0;
`endif
    repeat (3) @(posedge CLK);
    #1;
    check("rst_rdy", 64'(RDY_mult), 64'd0);
    check("rst_wr_en", 64'(EN_writeMem), 64'd0);
    check("rst_rd_en", 64'(EN_readMem), 64'd0);
    check("rst_valid", 64'(VALID_memVal), 64'd0);
    check("rst_fill", 64'(fill_count), 64'd0);
    check("rst_data", 64'(memVal_data), 64'd0);
    @(negedge CLK) rst_n = 1'b1;
    #1 check("rdy_before_edge", 64'(RDY_mult), 64'd0);
    step();
    check("rdy_rise", 64'(RDY_mult), 64'd1);

    // Full block with EN_mult held through drain
    rdc = 0;
    put_pair(16'd6, 16'd4, 1'b0, 32'd24, 1'b0);
    for (int i = 0; i < 63; i++) put_pair(IW'(i), 16'd2, 1'b0, 32'(i * 2), 1'b0);
    check("full_rdy_low", 64'(RDY_mult), 64'd0);
    check("full_fill", 64'(fill_count), 64'd64);
    repeat (2) step();
    check("ignored_fill", 64'(fill_count), 64'd64);
    read_block(64);

    // Signed/unsigned table, last pair accepted together with the flush request
    rdc = 0;
    for (int i = 0; i < 8; i++) put_pair(vt[i].a, vt[i].b, vt[i].s, vt[i].p, i == 7);
    idle();
    check("br_rdy_low", 64'(RDY_mult), 64'd0);
    check("br_fill", 64'(fill_count), 64'd8);
    read_block(8);

    // Partial flush
    rdc = 0;
    for (int i = 1; i <= 10; i++) put_pair(IW'(i), 16'd3, 1'b0, 32'(i * 3), 1'b0);
    idle();
    step();
    pulse_br();
    read_block(10);

    // Flush request on an empty block
    rdc = 0;
    pulse_br();
    repeat (8) step();
    check("br_empty_reads", 64'(rdc), 64'd0);
    check("br_empty_rdy", 64'(RDY_mult), 64'd1);

    // Reset during readout
    rdc = 0;
    for (int i = 0; i < 30; i++) put_pair(IW'(i), 16'd5, 1'b0, 32'(i * 5), 1'b0);
    idle();
    pulse_br();
    w = 0;
    while (VALID_memVal !== 1'b1 && w < 300) begin
      step();
      w++;
    end
    if (w >= 300) begin
      total++; bad++;
      $display("FAIL rst_valid_timeout got VALID_memVal=%b want 1", VALID_memVal);
    end
    repeat (20) step();
    check("beat20_before_rst", 64'(memVal_data), 64'(exp_blk[20]));
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(VALID_memVal), 64'd0);
    check("midrst_rd_en", 64'(EN_readMem), 64'd0);
    check("midrst_fill", 64'(fill_count), 64'd0);
    wq.delete();
    exp_fill = 0;
    @(negedge CLK) rst_n = 1'b1;
    #1 check("midrst_rdy_before_edge", 64'(RDY_mult), 64'd0);
    step();
    check("midrst_rdy_rise", 64'(RDY_mult), 64'd1);
    rdc = 0;
    put_pair(16'd7, 16'd9, 1'b0, 32'd63, 1'b0);
    idle();
    step();
    pulse_br();
    read_block(1);

    // Back-to-back full blocks
    for (int k = 2; k <= 6; k += 2) begin
      rdc = 0;
      for (int i = 0; i < 64; i++) put_pair(IW'(i), IW'(k), 1'b0, 32'(i * k), 1'b0);
      idle();
      read_block(64);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/multiplier_blockbuf.md
Name: multiplier_blockbuf

Overview:
- Parametrised second-generation multiply-and-buffer engine.
- Accepts a stream of operand pairs and multiplies them in a configurable pipeline. Products are written in order to an external 2-port memory (port B write, port A read).
- On request, streams the stored products back out in arrival order.
- New relative to the previous multiplier:
  - parametrised width and depth;
  - per-pair signed/unsigned mode;
  - configurable memory read latency;
  - partial-block flush, so a read is possible before the buffer is full.

Parameters:
- IN_WIDTH, 16, operand width; product width PW = 2*IN_WIDTH.
- ADDR_WIDTH, 6, memory address width; DEPTH = 2**ADDR_WIDTH entries.
- PIPE_STAGES, 2, multiplier pipeline depth (>=1), from accept edge to memory write.
- MEM_RD_LAT, 1, cycles from EN_readMem/readMem_addr to valid readMem_val (>=1).

Ports:
- CLK  in  1  clock; all logic is posedge CLK.
- rst_n  in  1  asynchronous active-low reset.
- EN_mult  in  1  operand pair valid; accepted when EN_mult && RDY_mult at a posedge.
- mult_input0  in  IN_WIDTH  operand A.
- mult_input1  in  IN_WIDTH  operand B.
- mult_signed  in  1  1 = two's-complement multiply for this pair, 0 = unsigned.
- EN_blockRead  in  1  request block readout; single-cycle pulse or level.
- readMem_val  in  PW  memory port A read data.
- RDY_mult  out  1  ready to accept a pair.
- EN_writeMem  out  1  memory write enable.
- writeMem_addr  out  ADDR_WIDTH  write address.
- writeMem_val  out  PW  write data.
- EN_readMem  out  1  memory read enable.
- readMem_addr  out  ADDR_WIDTH  read address.
- VALID_memVal  out  1  memVal_data holds a stored product.
- memVal_data  out  PW  readout data.
- fill_count  out  ADDR_WIDTH+1  number of accepted pairs in the current block (0..DEPTH).

Behaviour:
- Reset (async assert): all outputs 0; FSM = FILL; write pointer 0; all pipeline valid bits cleared.
  - RDY_mult is registered and rises on the first posedge after rst_n deasserts.
  - Reset mid-fill or mid-read abandons the operation. No memory access is issued after assertion.
- Arithmetic: product = full PW-bit product, never truncated. When mult_signed = 1, the operands are sign-extended; otherwise they are zero-extended. mult_signed travels down the pipeline with its pair.
- FSM states:
  - FILL: RDY_mult = 1 while fill_count < DEPTH. Each accept increments fill_count.
    - The accepted pair's product appears with EN_writeMem = 1 exactly PIPE_STAGES cycles after the accept edge, at writeMem_addr = accept index.
    - RDY_mult falls in the cycle after the DEPTH-th accept, then go to DRAIN.
    - EN_blockRead with fill_count > 0 also goes to DRAIN, and RDY_mult falls next cycle. A pair accepted on the same edge as EN_blockRead is included.
    - EN_blockRead with fill_count = 0 is ignored.
  - DRAIN: RDY_mult = 0. Wait until the pipeline holds no valid pair (last write issued), then go to READ.
  - READ: issue EN_readMem = 1 with readMem_addr = 0,1,...,fill_count-1 on consecutive cycles.
    - Each returned word is registered onto memVal_data, so beat i is valid MEM_RD_LAT+1 cycles after read i is issued.
    - VALID_memVal is high for exactly fill_count consecutive cycles, beat i = entry i.
    - After the last beat: fill_count = 0, write pointer = 0, state = FILL, and RDY_mult = 1 in the cycle after the last VALID beat.
- EN_mult while RDY_mult = 0 is ignored, with no write. EN_blockRead in DRAIN or READ is ignored.
- EN_writeMem and EN_readMem never address the same entry in the same cycle.

Optional Feature:
- Macro MULT_BLOCKBUF_ACC_EN.
- When defined:
  - An extra input port mult_acc (1 bit) is added.
  - A pair accepted with mult_acc = 1 stores (its product + the previously stored product in this block), modulo 2**PW. An internal running copy of the last written value is used; no memory read is needed.
  - If mult_acc = 1 on the first pair of a block, the pair stores its plain product.
- When undefined: the port is absent and every entry stores its plain product.

Test Plan:
- Defaults used throughout: DEPTH=64, PIPE_STAGES=2, MEM_RD_LAT=1.
- Full block: after reset, pair (6,4) then (i,2) for i=0..62, unsigned -> RDY_mult falls after the 64th accept, fill_count=64; then EN_blockRead -> 64 consecutive VALID beats 24,0,2,4,...,124, then RDY_mult=1, fill_count=0.
- Signed mode: (0xFFFD,5) with mult_signed=1 -> 0xFFFFFFF1; same operands with mult_signed=0 -> 0x0004FFF1.
- Partial flush: 10 pairs (i,3) for i=1..10, then EN_blockRead -> exactly 10 beats 3,6,...,30; VALID low on the 11th cycle; next block writes from addr 0.
- Ignored requests: EN_mult held high through DRAIN/READ -> no EN_writeMem and no fill_count change; EN_blockRead at fill_count=0 -> no reads issued.
- Reset mid-read at beat 20 -> VALID_memVal and EN_readMem go 0 immediately; RDY_mult=1 one edge after release; next accept is written to addr 0.
- Back-to-back: 3 full blocks with (i,k), k=2,4,6 -> each readout matches i*k with no stale data.
